// File: rtl/nios1_nios2_qsys_0_oci_pkg.sv
`default_nettype none
// ============================================================================
// nios1_nios2_qsys_0_oci_pkg -- shared widths and FSM encoding for trace packer
// Revision: 1.0
// ============================================================================
package nios1_nios2_qsys_0_oci_pkg;

    localparam int FRAG_W         = 6;
    localparam int FRAGS_PER_WORD = 5;
    localparam int WORD_W         = FRAG_W * FRAGS_PER_WORD;
    localparam int COUNT_W        = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } dct_state_t;

endpackage
`default_nettype wire

// File: rtl/nios1_nios2_qsys_0_oci_dct_outreg.sv
`default_nettype none
// ============================================================================
// nios1_nios2_qsys_0_oci_dct_outreg -- single-entry valid/ready output register
// Revision: 1.0
// ============================================================================
module nios1_nios2_qsys_0_oci_dct_outreg #(
    parameter int DATA_W  = 30,
    parameter int COUNT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [DATA_W-1:0]  load_data,
    input  logic [COUNT_W-1:0] load_count,
    input  logic               ready,
    output logic               valid,
    output logic [DATA_W-1:0]  data,
    output logic [COUNT_W-1:0] count,
    output logic               free
);

    // Free when empty, or when the held word leaves on this same edge.
    assign free = !valid || ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            count <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            count <= load_count;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/nios1_nios2_qsys_0_oci_dct_ctrl.sv
`default_nettype none
// ============================================================================
// nios1_nios2_qsys_0_oci_dct_ctrl -- packs trace fragments into words, with flush
// Revision: 1.0
// ============================================================================
module nios1_nios2_qsys_0_oci_dct_ctrl
    import nios1_nios2_qsys_0_oci_pkg::*;
#(
    parameter int FRAG_W         = nios1_nios2_qsys_0_oci_pkg::FRAG_W,
    parameter int FRAGS_PER_WORD = nios1_nios2_qsys_0_oci_pkg::FRAGS_PER_WORD
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             trace_en,
    input  logic                             frag_valid,
    input  logic [FRAG_W-1:0]                frag_data,
    output logic                             frag_ready,
    output logic                             word_valid,
    output logic [FRAG_W*FRAGS_PER_WORD-1:0] word_data,
    output logic [COUNT_W-1:0]               word_count,
    input  logic                             word_ready,
    input  logic                             flush_req,
    output logic                             flush_done,
    output logic [FRAG_W*FRAGS_PER_WORD-1:0] dct_buffer,
    output logic [COUNT_W-1:0]               dct_count
);

    localparam int                 WORD_BITS  = FRAG_W * FRAGS_PER_WORD;
    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(FRAGS_PER_WORD);

    dct_state_t           state;
    dct_state_t           state_next;
    logic                 out_free;
    logic                 transfer;
    logic                 accept;
    logic [WORD_BITS-1:0] buffer_next;
    logic [COUNT_W-1:0]   count_next;

    assign transfer   = ((state == ST_RUN   && dct_count == FULL_COUNT) ||
                         (state == ST_FLUSH && dct_count != '0)) && out_free;
    assign frag_ready = !reset && trace_en && (state == ST_RUN) &&
                        ((dct_count < FULL_COUNT) || transfer);
    assign accept     = frag_valid && frag_ready;
    assign flush_done = (state == ST_DONE);

    // A transfer empties the accumulator first, so a fragment taken on the
    // same edge lands in slot 0.
    always_comb begin
        buffer_next = dct_buffer;
        count_next  = dct_count;
        if (transfer) begin
            buffer_next = '0;
            count_next  = '0;
        end
        if (accept) begin
            for (int k = 0; k < FRAGS_PER_WORD; k++) begin
                if (count_next == COUNT_W'(k)) begin
                    buffer_next[k*FRAG_W +: FRAG_W] = frag_data;
                end
            end
            count_next = count_next + COUNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:   if (flush_req) state_next = ST_FLUSH;
            ST_FLUSH: if (dct_count == '0 && !word_valid) state_next = ST_DONE;
            ST_DONE:  state_next = ST_DONE;
            default:  state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_RUN;
            dct_buffer <= '0;
            dct_count  <= '0;
        end else begin
            state      <= state_next;
            dct_buffer <= buffer_next;
            dct_count  <= count_next;
        end
    end

    nios1_nios2_qsys_0_oci_dct_outreg #(
        .DATA_W  (WORD_BITS),
        .COUNT_W (COUNT_W)
    ) u_outreg (
        .clk        (clk),
        .reset      (reset),
        .load       (transfer),
        .load_data  (dct_buffer),
        .load_count (dct_count),
        .ready      (word_ready),
        .valid      (word_valid),
        .data       (word_data),
        .count      (word_count),
        .free       (out_free)
    );

endmodule
`default_nettype wire

// File: tb/tb_nios1_nios2_qsys_0_oci_dct_ctrl.sv
`default_nettype none
// ============================================================================
// tb_nios1_nios2_qsys_0_oci_dct_ctrl -- directed self-checking bench for the trace packer
// Revision: 1.0
// ============================================================================
module tb_nios1_nios2_qsys_0_oci_dct_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        trace_en;
    logic        frag_valid;
    logic [5:0]  frag_data;
    logic        frag_ready;
    logic        word_valid;
    logic [29:0] word_data;
    logic [3:0]  word_count;
    logic        word_ready;
    logic        flush_req;
    logic        flush_done;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    nios1_nios2_qsys_0_oci_dct_ctrl #(
        .FRAG_W         (6),
        .FRAGS_PER_WORD (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .trace_en   (trace_en),
        .frag_valid (frag_valid),
        .frag_data  (frag_data),
        .frag_ready (frag_ready),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_count (word_count),
        .word_ready (word_ready),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled there too.
    task automatic tick;
        @(negedge clk);
    endtask

    // Expected word for n consecutive fragment values starting at first.
    function automatic logic [29:0] pack(input int first, input int n);
        logic [29:0] w;
        w = '0;
        for (int k = 0; k < n; k++) w[k*6 +: 6] = 6'(first + k);
        return w;
    endfunction

    initial begin
        reset = 1'b1; trace_en = 1'b1; frag_valid = 1'b1; frag_data = 6'h2A;
        word_ready = 1'b0; flush_req = 1'b0;
        tick; tick;
        chk("rst_frag_ready", frag_ready, 0);
        chk("rst_word_valid", word_valid, 0);
        chk("rst_word_data", word_data, 0);
        chk("rst_dct_count", dct_count, 0);
        chk("rst_flush_done", flush_done, 0);

        // Five fragments back to back, sink always ready
        reset = 1'b0; word_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            frag_data = 6'(i);
            tick;
        end
        frag_valid = 1'b0;
        chk("t1_count_full", dct_count, 5);
        chk("t1_buffer", dct_buffer, pack(1, 5));
        chk("t1_not_yet_valid", word_valid, 0);
        chk("t1_ready_on_transfer", frag_ready, 1);
        tick;
        chk("t1_word_valid", word_valid, 1);
        chk("t1_word_data", word_data, 32'h0510_3081);
        chk("t1_word_count", word_count, 5);
        chk("t1_acc_cleared", dct_count, 0);
        tick;
        chk("t1_word_taken", word_valid, 0);

        // Sink stalled: ten fragments fill output register and accumulator
        word_ready = 1'b0; frag_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            frag_data = 6'(10 + i);
            #1;
            chk("t2_frag_ready", frag_ready, 1);
            tick;
        end
        frag_data = 6'h14;
        #1;
        chk("t2_stall_ready", frag_ready, 0);
        chk("t2_stall_count", dct_count, 5);
        chk("t2_word0_valid", word_valid, 1);
        chk("t2_word0_data", word_data, pack(10, 5));
        chk("t2_word0_count", word_count, 5);
        frag_valid = 1'b0; word_ready = 1'b1;
        tick;
        chk("t2_word1_valid", word_valid, 1);
        chk("t2_word1_data", word_data, pack(15, 5));
        chk("t2_acc_empty", dct_count, 0);

        // Capture disabled while a word is still pending
        word_ready = 1'b0; trace_en = 1'b0; frag_valid = 1'b1;
        #1;
        chk("t3_ready_disabled", frag_ready, 0);
        tick;
        chk("t3_count_stays", dct_count, 0);
        chk("t3_word_held", word_valid, 1);
        chk("t3_data_held", word_data, pack(15, 5));
        word_ready = 1'b1;
        tick;
        chk("t3_word_drained", word_valid, 0);
        chk("t3_count_still0", dct_count, 0);

        // Three 0x3F fragments, flush requested together with the third
        trace_en = 1'b1; frag_valid = 1'b1; word_ready = 1'b0; frag_data = 6'h3F;
        tick; tick;
        flush_req = 1'b1;
        tick;
        flush_req = 1'b0; frag_valid = 1'b0;
        chk("t4_third_taken", dct_count, 3);
        chk("t4_ready_in_flush", frag_ready, 0);
        chk("t4_not_done", flush_done, 0);
        tick;
        chk("t4_flush_valid", word_valid, 1);
        chk("t4_flush_data", word_data, 32'h0003_FFFF);
        chk("t4_flush_count", word_count, 3);
        chk("t4_acc_cleared", dct_count, 0);
        tick;
        chk("t4_flush_held", word_valid, 1);
        chk("t4_done_waits", flush_done, 0);
        word_ready = 1'b1;
        tick;
        chk("t4_flush_taken", word_valid, 0);
        tick;
        chk("t4_done", flush_done, 1);
        flush_req = 1'b1; frag_valid = 1'b1;
        tick;
        flush_req = 1'b0;
        tick;
        chk("t4_done_sticky", flush_done, 1);
        chk("t4_ready_done", frag_ready, 0);
        chk("t4_no_accept", dct_count, 0);

        // Reset with four fragments buffered and a word pending
        reset = 1'b1; frag_valid = 1'b0;
        tick;
        reset = 1'b0; word_ready = 1'b0; frag_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            frag_data = 6'(i + 1);
            tick;
        end
        frag_valid = 1'b0;
        chk("t5_pre_count", dct_count, 4);
        chk("t5_pre_valid", word_valid, 1);
        reset = 1'b1; frag_valid = 1'b1;
        #1;
        chk("t5_ready_in_reset", frag_ready, 0);
        tick;
        chk("t5_word_valid", word_valid, 0);
        chk("t5_word_data", word_data, 0);
        chk("t5_word_count", word_count, 0);
        chk("t5_dct_count", dct_count, 0);
        chk("t5_dct_buffer", dct_buffer, 0);
        chk("t5_flush_done", flush_done, 0);
        reset = 1'b0; frag_valid = 1'b0; word_ready = 1'b1;
        tick; tick;
        chk("t5_no_stale_word", word_valid, 0);
        chk("t5_acc_empty", dct_count, 0);

        // Flush with nothing buffered
        flush_req = 1'b1;
        tick;
        flush_req = 1'b0;
        chk("t6_no_word", word_valid, 0);
        chk("t6_not_done_yet", flush_done, 0);
        tick;
        chk("t6_done", flush_done, 1);
        chk("t6_still_no_word", word_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
